// File: rtl/multicycle_control_if.sv
// Control bundle between the multi-cycle sequencer and the shared datapath/memory.
// The master side is the sequencer; the slave side is the datapath it steers.
interface multicycle_control_if #(
    parameter int unsigned CNT_W = 32
);
    logic [6:0]       ir_opcode;
    logic             mem_ready;
    logic             pc_write;
    logic             ir_write;
    logic             i_or_d;
    logic             mem_read;
    logic             mem_write;
    logic             mem_to_reg;
    logic             alu_src;
    logic [1:0]       alu_op;
    logic             branch;
    logic             reg_write;
    logic             illegal;
    logic             timeout;
    logic             halted;
    logic [CNT_W-1:0] instret;

    modport master (
        input  ir_opcode, mem_ready,
        output pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg,
               alu_src, alu_op, branch, reg_write, illegal, timeout, halted, instret
    );

    modport slave (
        output ir_opcode, mem_ready,
        input  pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg,
               alu_src, alu_op, branch, reg_write, illegal, timeout, halted, instret
    );
endinterface

// File: rtl/multicycle_control.sv
// Sequencing FSM for the multi-cycle RISC-V core: FETCH/DECODE/EXEC/MEM/WB over a shared
// ALU and unified memory port, with memory timeout, illegal-opcode trap and retire counter.
module multicycle_control #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TO_W           = 8,
    parameter int unsigned CNT_W          = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    multicycle_control_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_t;

    typedef enum logic [2:0] {
        C_R, C_IALU, C_LOAD, C_STORE, C_BRANCH
    } cls_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    cls_t             cls;
    logic [TO_W-1:0]  to_cnt;
    logic [CNT_W-1:0] instret_q;
    logic             illegal_q;
    logic             timeout_q;

    logic             dec_legal;
    cls_t             dec_cls;

    // Opcode class decode; only consumed in DECODE.
    always_comb begin
        dec_legal = 1'b1;
        dec_cls   = C_R;
        case (bus.ir_opcode[6:2])
            5'b01100: dec_cls = C_R;
            5'b00100: dec_cls = C_IALU;
            5'b00000: dec_cls = C_LOAD;
            5'b01000: dec_cls = C_STORE;
            5'b11000: dec_cls = C_BRANCH;
            default:  dec_legal = 1'b0;
        endcase
        if (bus.ir_opcode[1:0] != 2'b11) begin
            dec_legal = 1'b0;
        end
    end

    // The timeout counter is zero whenever no request is outstanding, so every
    // entry into FETCH or MEM starts a fresh budget.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cls       <= C_R;
            to_cnt    <= '0;
            instret_q <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            to_cnt <= '0;
            case (state)
                S_IDLE: state <= S_FETCH;
                S_FETCH: begin
                    if (bus.mem_ready) begin
                        state <= S_DECODE;
                    end else if (to_cnt == TO_LAST) begin
                        timeout_q <= 1'b1;
                        state     <= S_TRAP;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                S_DECODE: begin
                    if (dec_legal) begin
                        cls   <= dec_cls;
                        state <= S_EXEC;
                    end else begin
                        illegal_q <= 1'b1;
                        state     <= S_TRAP;
                    end
                end
                S_EXEC: begin
                    case (cls)
                        C_BRANCH: begin
                            state     <= S_FETCH;
                            instret_q <= instret_q + CNT_W'(1);
                        end
                        C_LOAD, C_STORE: state <= S_MEM;
                        default:         state <= S_WB;
                    endcase
                end
                S_MEM: begin
                    if (bus.mem_ready) begin
                        if (cls == C_LOAD) begin
                            state <= S_WB;
                        end else begin
                            state     <= S_FETCH;
                            instret_q <= instret_q + CNT_W'(1);
                        end
                    end else if (to_cnt == TO_LAST) begin
                        timeout_q <= 1'b1;
                        state     <= S_TRAP;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                S_WB: begin
                    state     <= S_FETCH;
                    instret_q <= instret_q + CNT_W'(1);
                end
                S_TRAP:  state <= S_TRAP;
                default: state <= S_TRAP;
            endcase
        end
    end

    // Datapath controls decode from state/class; only the fetch strobes look at mem_ready.
    always_comb begin
        bus.pc_write   = 1'b0;
        bus.ir_write   = 1'b0;
        bus.i_or_d     = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.alu_src    = 1'b0;
        bus.alu_op     = 2'b00;
        bus.branch     = 1'b0;
        bus.reg_write  = 1'b0;
        case (state)
            S_FETCH: begin
                bus.mem_read = 1'b1;
                bus.ir_write = bus.mem_ready;
                bus.pc_write = bus.mem_ready;
            end
            S_EXEC: begin
                case (cls)
                    C_R:      bus.alu_op = 2'b10;
                    C_IALU: begin
                        bus.alu_src = 1'b1;
                        bus.alu_op  = 2'b10;
                    end
                    C_BRANCH: begin
                        bus.alu_op = 2'b01;
                        bus.branch = 1'b1;
                    end
                    default:  bus.alu_src = 1'b1;
                endcase
            end
            S_MEM: begin
                bus.i_or_d    = 1'b1;
                bus.mem_read  = (cls == C_LOAD);
                bus.mem_write = (cls == C_STORE);
            end
            S_WB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = (cls == C_LOAD);
            end
            default: ;
        endcase
    end

    assign bus.illegal = illegal_q;
    assign bus.timeout = timeout_q;
    assign bus.halted  = (state == S_TRAP);
    assign bus.instret = instret_q;

endmodule
